// File: rtl/vec_pkg.sv
// Shared vector definitions: vlmul encoding, group-size decode and micro-op record.
package vec_pkg;

    localparam int VEC_REG_W = 5;
    localparam int VEC_CNT_W = 3;

    localparam logic [2:0] VLMUL_1 = 3'b000;
    localparam logic [2:0] VLMUL_2 = 3'b001;
    localparam logic [2:0] VLMUL_4 = 3'b010;
    localparam logic [2:0] VLMUL_8 = 3'b011;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_ISSUE
    } seq_state_t;

    typedef struct packed {
        logic [VEC_REG_W-1:0] vd;
        logic [VEC_REG_W-1:0] vs1;
        logic [VEC_REG_W-1:0] vs2;
        logic [VEC_CNT_W-1:0] idx;
        logic                 first;
        logic                 last;
    } uop_t;

    // Number of registers in a group; fractional and reserved encodings count as one.
    function automatic logic [3:0] lmul_count(input logic [2:0] vlmul);
        logic [3:0] n;
        case (vlmul)
            VLMUL_2: n = 4'd2;
            VLMUL_4: n = 4'd4;
            VLMUL_8: n = 4'd8;
            default: n = 4'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vec_group_sequencer.sv
// Expands a grouped vector instruction in ID into one micro-op per ID->EX advance,
// holding PC and IF/ID via grouping_stall until the last micro-op issues.
module vec_group_sequencer
    import vec_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ifid_valid,
    input  logic             vec_op,
    input  logic [2:0]       vlmul,
    input  logic [REG_W-1:0] vd,
    input  logic [REG_W-1:0] vs1,
    input  logic [REG_W-1:0] vs2,
    input  logic             advance,
    input  logic             flush,
    output logic             grouping_stall,
    output logic [REG_W-1:0] uop_vd,
    output logic [REG_W-1:0] uop_vs1,
    output logic [REG_W-1:0] uop_vs2,
    output logic [CNT_W-1:0] uop_idx,
    output logic             uop_first,
    output logic             uop_last,
    output logic             busy
);

    seq_state_t       state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic [CNT_W-1:0] last_idx, next_last_idx;
    logic [REG_W-1:0] base_vd, base_vs1, base_vs2;
    logic [REG_W-1:0] next_base_vd, next_base_vs1, next_base_vs2;
    logic [3:0]       group_n;
    logic             group_active;
    logic [REG_W-1:0] cnt_ext;

    assign group_n      = lmul_count(vlmul);
    assign group_active = ifid_valid & vec_op & (group_n > 4'd1);
    assign cnt_ext      = REG_W'(cnt);
    assign busy         = (state == SEQ_ISSUE);

    // State, counter and latched group base; reset abandons any partial group.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= SEQ_IDLE;
            cnt      <= '0;
            last_idx <= '0;
            base_vd  <= '0;
            base_vs1 <= '0;
            base_vs2 <= '0;
        end else begin
            state    <= next_state;
            cnt      <= next_cnt;
            last_idx <= next_last_idx;
            base_vd  <= next_base_vd;
            base_vs1 <= next_base_vs1;
            base_vs2 <= next_base_vs2;
        end
    end

    // Next-state and micro-op outputs; flush overrides advance, and advance never reaches grouping_stall.
    always_comb begin
        next_state     = state;
        next_cnt       = cnt;
        next_last_idx  = last_idx;
        next_base_vd   = base_vd;
        next_base_vs1  = base_vs1;
        next_base_vs2  = base_vs2;
        uop_vd         = vd;
        uop_vs1        = vs1;
        uop_vs2        = vs2;
        uop_idx        = '0;
        uop_first      = 1'b1;
        uop_last       = 1'b1;
        grouping_stall = 1'b0;

        case (state)
            SEQ_IDLE: begin
                uop_last       = !group_active;
                grouping_stall = group_active & !flush;
                if (!flush && group_active && advance) begin
                    next_state    = SEQ_ISSUE;
                    next_cnt      = CNT_W'(1);
                    next_last_idx = CNT_W'(group_n - 4'd1);
                    next_base_vd  = vd;
                    next_base_vs1 = vs1;
                    next_base_vs2 = vs2;
                end
            end
            SEQ_ISSUE: begin
                uop_vd         = base_vd + cnt_ext;
                uop_vs1        = base_vs1 + cnt_ext;
                uop_vs2        = base_vs2 + cnt_ext;
                uop_idx        = cnt;
                uop_first      = 1'b0;
                uop_last       = (cnt == last_idx);
                grouping_stall = !uop_last & !flush;
                if (flush) begin
                    next_state    = SEQ_IDLE;
                    next_cnt      = '0;
                    next_last_idx = '0;
                    next_base_vd  = '0;
                    next_base_vs1 = '0;
                    next_base_vs2 = '0;
                end else if (advance) begin
                    if (uop_last) begin
                        next_state = SEQ_IDLE;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                next_state = SEQ_IDLE;
                next_cnt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_vec_group_sequencer.sv
// Directed bench for vec_group_sequencer with hand-computed micro-op sequences.
module tb_vec_group_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       ifid_valid, vec_op, advance, flush;
    logic [2:0] vlmul;
    logic [4:0] vd, vs1, vs2;
    logic       grouping_stall, uop_first, uop_last, busy;
    logic [4:0] uop_vd, uop_vs1, uop_vs2;
    logic [2:0] uop_idx;
    logic [21:0] obs;
    logic [21:0] exp_v;
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    vec_group_sequencer #(.REG_W(5), .CNT_W(3)) dut (
        .clock(clock), .reset(reset), .ifid_valid(ifid_valid), .vec_op(vec_op),
        .vlmul(vlmul), .vd(vd), .vs1(vs1), .vs2(vs2), .advance(advance), .flush(flush),
        .grouping_stall(grouping_stall), .uop_vd(uop_vd), .uop_vs1(uop_vs1), .uop_vs2(uop_vs2),
        .uop_idx(uop_idx), .uop_first(uop_first), .uop_last(uop_last), .busy(busy)
    );

    always #5 clock = ~clock;

    // Field order: vd, vs1, vs2, idx, stall, first, last, busy
    assign obs = {uop_vd, uop_vs1, uop_vs2, uop_idx, grouping_stall, uop_first, uop_last, busy};

    function automatic logic [21:0] pack(input int pvd, input int pvs1, input int pvs2, input int pidx,
                                         input bit st, input bit fi, input bit la, input bit bu);
        return {5'(pvd), 5'(pvs1), 5'(pvs2), 3'(pidx), st, fi, la, bu};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input bit v, input bit vo, input logic [2:0] lm,
                          input int a, input int b, input int c);
        ifid_valid = v; vec_op = vo; vlmul = lm;
        vd = 5'(a); vs1 = 5'(b); vs2 = 5'(c);
    endtask

    task automatic test_reset();
        reset = 1'b1; advance = 1'b1; flush = 1'b0;
        set_op(0, 0, 3'b000, 0, 0, 0);
        #1;
        exp_v = pack(0, 0, 0, 0, 0, 1, 1, 0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("[TB] FAIL reset_idle got %h expected %h", obs, exp_v); end
        else passes++;
        set_op(1, 1, 3'b010, 8, 16, 24);
        #1;
        exp_v = pack(8, 16, 24, 0, 1, 1, 0, 0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("[TB] FAIL reset_grouped_inputs got %h expected %h", obs, exp_v); end
        else passes++;
        step();
        checks++;
        if (obs !== exp_v) begin fails++; $display("[TB] FAIL reset_held_edge got %h expected %h", obs, exp_v); end
        else passes++;
        set_op(0, 0, 3'b000, 0, 0, 0);
        reset = 1'b0;
        step();
        exp_v = pack(0, 0, 0, 0, 0, 1, 1, 0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("[TB] FAIL reset_released got %h expected %h", obs, exp_v); end
        else passes++;
    endtask

    task automatic test_lmul4();
        advance = 1'b1;
        set_op(1, 1, 3'b010, 8, 16, 24);
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_v = pack(8 + k, 16 + k, 24 + k, k, k < 3, k == 0, k == 3, k > 0);
            checks++;
            if (obs !== exp_v) begin fails++; $display("[TB] FAIL lmul4 idx%0d got %h expected %h", k, obs, exp_v); end
            else passes++;
            if (k == 3) ifid_valid = 1'b0;
            step();
        end
        exp_v = pack(8, 16, 24, 0, 0, 1, 1, 0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("[TB] FAIL lmul4_done got %h expected %h", obs, exp_v); end
        else passes++;
    endtask

    task automatic test_hold();
        advance = 1'b1;
        set_op(1, 1, 3'b001, 2, 4, 6);
        #1;
        exp_v = pack(2, 4, 6, 0, 1, 1, 0, 0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("[TB] FAIL hold_idx0 got %h expected %h", obs, exp_v); end
        else passes++;
        step();
        for (int h = 0; h < 3; h++) begin
            advance = (h == 2);
            if (h == 2) ifid_valid = 1'b0;
            #1;
            exp_v = pack(3, 5, 7, 1, 0, 0, 1, 1);
            checks++;
            if (obs !== exp_v) begin fails++; $display("[TB] FAIL hold_idx1_cycle%0d got %h expected %h", h, obs, exp_v); end
            else passes++;
            step();
        end
        exp_v = pack(2, 4, 6, 0, 0, 1, 1, 0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("[TB] FAIL hold_done got %h expected %h", obs, exp_v); end
        else passes++;
        advance = 1'b1;
    endtask

    task automatic test_flush();
        advance = 1'b1;
        set_op(1, 1, 3'b011, 0, 8, 16);
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_v = pack(k, 8 + k, 16 + k, k, 1, k == 0, 0, k > 0);
            checks++;
            if (obs !== exp_v) begin fails++; $display("[TB] FAIL flush_pre_idx%0d got %h expected %h", k, obs, exp_v); end
            else passes++;
            if (k < 3) step();
        end
        flush = 1'b1;
        #1;
        exp_v = pack(3, 11, 19, 3, 0, 0, 0, 1);
        checks++;
        if (obs !== exp_v) begin fails++; $display("[TB] FAIL flush_cycle got %h expected %h", obs, exp_v); end
        else passes++;
        step();
        flush = 1'b0;
        ifid_valid = 1'b0;
        #1;
        exp_v = pack(0, 8, 16, 0, 0, 1, 1, 0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("[TB] FAIL flush_after got %h expected %h", obs, exp_v); end
        else passes++;
        ifid_valid = 1'b1;
        #1;
        exp_v = pack(0, 8, 16, 0, 1, 1, 0, 0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("[TB] FAIL flush_restart_idx0 got %h expected %h", obs, exp_v); end
        else passes++;
        step();
        exp_v = pack(1, 9, 17, 1, 1, 0, 0, 1);
        checks++;
        if (obs !== exp_v) begin fails++; $display("[TB] FAIL flush_restart_idx1 got %h expected %h", obs, exp_v); end
        else passes++;
        flush = 1'b1;
        step();
        flush = 1'b0;
        ifid_valid = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [2:0] lm_tab [3];
        bit         vo_tab [3];
        lm_tab = '{3'b000, 3'b101, 3'b011};
        vo_tab = '{1'b1, 1'b1, 1'b0};
        advance = 1'b1;
        for (int t = 0; t < 3; t++) begin
            set_op(1, vo_tab[t], lm_tab[t], 3 + t, 5 + t, 7 + t);
            #1;
            exp_v = pack(3 + t, 5 + t, 7 + t, 0, 0, 1, 1, 0);
            checks++;
            if (obs !== exp_v) begin fails++; $display("[TB] FAIL pass%0d_now got %h expected %h", t, obs, exp_v); end
            else passes++;
            step();
            checks++;
            if (obs !== exp_v) begin fails++; $display("[TB] FAIL pass%0d_next got %h expected %h", t, obs, exp_v); end
            else passes++;
        end
        ifid_valid = 1'b0;
    endtask

    task automatic test_wrap();
        advance = 1'b1;
        set_op(1, 1, 3'b010, 30, 29, 28);
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_v = pack((30 + k) % 32, (29 + k) % 32, (28 + k) % 32, k, k < 3, k == 0, k == 3, k > 0);
            checks++;
            if (obs !== exp_v) begin fails++; $display("[TB] FAIL wrap idx%0d got %h expected %h", k, obs, exp_v); end
            else passes++;
            if (k == 3) ifid_valid = 1'b0;
            step();
        end
        checks++;
        if (busy !== 1'b0) begin fails++; $display("[TB] FAIL wrap_done busy got %b expected 0", busy); end
        else passes++;
    endtask

    task automatic test_reset_mid();
        advance = 1'b1;
        set_op(1, 1, 3'b011, 1, 2, 3);
        step();
        step();
        exp_v = pack(3, 4, 5, 2, 1, 0, 0, 1);
        checks++;
        if (obs !== exp_v) begin fails++; $display("[TB] FAIL rstmid_idx2 got %h expected %h", obs, exp_v); end
        else passes++;
        #1 reset = 1'b1;
        #1;
        exp_v = pack(1, 2, 3, 0, 1, 1, 0, 0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("[TB] FAIL rstmid_async got %h expected %h", obs, exp_v); end
        else passes++;
        #1 reset = 1'b0;
        #1;
        checks++;
        if (obs !== exp_v) begin fails++; $display("[TB] FAIL rstmid_released got %h expected %h", obs, exp_v); end
        else passes++;
        step();
        exp_v = pack(2, 3, 4, 1, 1, 0, 0, 1);
        checks++;
        if (obs !== exp_v) begin fails++; $display("[TB] FAIL rstmid_restart_idx1 got %h expected %h", obs, exp_v); end
        else passes++;
        flush = 1'b1;
        step();
        flush = 1'b0;
        ifid_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lmul4();
        test_hold();
        test_flush();
        test_passthrough();
        test_wrap();
        test_reset_mid();
        if (passes + fails != checks) $display("[TB] FAIL bookkeeping got %0d expected %0d", passes + fails, checks);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vec_group_sequencer.md
# vec_group_sequencer

Splits a grouped RVV instruction (LMUL > 1) sitting in ID into LMUL single-register micro-ops, issued one per ID→EX advance. It sits in the ID stage beside the stall-control unit. It drives that unit's `grouping_stall` input, which holds PC and IF/ID while the group is expanded. Scalar instructions and LMUL ≤ 1 vector instructions pass through unchanged with no added latency.

## Interface
Parameters:
- `REG_W`, 5: register index width (32 architectural vector registers).
- `CNT_W`, 3: micro-op index width (max group size 8).

Ports:
- `clock` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ifid_valid` in 1: IF/ID holds a valid instruction.
- `vec_op` in 1: the ID instruction is a vector op subject to register grouping.
- `vlmul` in 3: vtype.vlmul encoding. 000=1, 001=2, 010=4, 011=8; 1xx gives a count of 1.
- `vd`, `vs1`, `vs2` in REG_W each: base register fields from the decoder.
- `advance` in 1: the ID→EX register accepts this cycle (`write_idex` from stall control). Must not depend combinationally on `grouping_stall`.
- `flush` in 1: pipeline kill (trap, taken branch, or flushPipeline).
- `grouping_stall` out 1: freeze PC and IF/ID; feeds stall control.
- `uop_vd`, `uop_vs1`, `uop_vs2` out REG_W each: register indices of the current micro-op.
- `uop_idx` out CNT_W: index of the current micro-op within the group.
- `uop_first`, `uop_last` out 1: the current micro-op is the first / last of its group.
- `busy` out 1: the FSM is in ISSUE.

## Operation
- Group size: n = 1/2/4/8 from `vlmul`, per the `vlmul` port encoding. Grouping is active when `ifid_valid & vec_op & n>1`.
- FSM states:
  - IDLE: counter `cnt`=0; no instruction latched.
  - ISSUE: `cnt` in 1..n-1. Base registers and n are latched.
- In IDLE:
  - Outputs are combinational from the inputs: `uop_vd`=`vd`, `uop_vs1`=`vs1`, `uop_vs2`=`vs2`, `uop_idx`=0, `uop_first`=1.
  - `uop_last` = !(grouping active).
  - `grouping_stall` = grouping active & !`flush`.
  - If grouping is active & `advance` & !`flush`: latch `vd`/`vs1`/`vs2`/n, set `cnt`=1, go to ISSUE.
- In ISSUE:
  - Outputs come from the latched base + `cnt`, with 5-bit wrap-around (mod 32). `uop_idx`=`cnt`, `uop_first`=0.
  - `uop_last` = (`cnt`==n-1).
  - `grouping_stall` = !`uop_last` & !`flush`. It deasserts on the last micro-op so IF/ID advances together with it.
  - On `advance`: if last, go to IDLE with `cnt`=0; else `cnt`+1.
  - On !`advance`: hold all state.
  - Changes on ID inputs are ignored while in ISSUE.
- `flush` has priority over `advance` in every state: next state IDLE, `cnt`=0, nothing latched.
- Register-group alignment is not checked here; the decoder raises illegal-instruction for misaligned groups.

## Timing
- Reset values (reset asserted, or in the first cycle after):
  - State IDLE, `cnt`=0, latched registers 0.
  - `busy`=0, `uop_idx`=0, `uop_first`=1.
  - `grouping_stall`=0 unless a grouped op is present on the inputs.
- Reset asserted mid-sequence returns the FSM to IDLE asynchronously; no partial-group state survives.
- An n-micro-op group needs n advancing cycles. `grouping_stall` is high for the first n-1 of them, plus any non-advancing cycles before the last micro-op.
- No latency is added for n=1 or scalar instructions. The micro-op fields are valid in the same cycle they are consumed by ID/EX.
- `grouping_stall` and `busy` are glitch-free relative to the register outputs. There is no combinational path `advance`→`grouping_stall`.

## Structure
- Shared package `vec_pkg`:
  - `VLMUL_*` encoding constants.
  - `lmul_count()` function (vlmul → n).
  - Micro-op struct typedef {vd, vs1, vs2, idx, first, last}.
  - The `vlmul` encoding is also used by the vector decoder.
- A single module. The FSM plus counter is small enough that no sub-module is warranted.

## Test plan
- LMUL=4 (`vlmul`=010), `vd`=8, `vs1`=16, `vs2`=24, `advance`=1 → four micro-ops:
  - `uop_vd` 8,9,10,11; `uop_vs1` 16..19; `uop_vs2` 24..27.
  - `uop_idx` 0..3; `grouping_stall` 1,1,1,0; `uop_last` only on idx 3.
- LMUL=2 with `advance`=0 for 2 cycles at idx 1 → idx 1 is held for 3 cycles. `grouping_stall` stays 0 throughout and returns to IDLE after the advancing cycle.
- LMUL=8 with `flush` at idx 3 → `grouping_stall`=0 in the flush cycle; next cycle `busy`=0 and `cnt`=0.
- `vlmul`=000, then `vlmul`=101, then a scalar instruction (`vec_op`=0) → `grouping_stall` never asserted; `uop_*` equal the inputs; `uop_first`=`uop_last`=1.
- Wrap-around: `vd`=30, LMUL=4 → `uop_vd` 30,31,0,1.
- Reset pulse during ISSUE at idx 2 of LMUL=8 → outputs return to reset values immediately. The next grouped op starts again at idx 0.
